// File: rtl/rr_arbiter5_if.sv
// rr_arbiter5_if: request/grant bundle for the five-way round-robin arbiter
interface rr_arbiter5_if;
    logic req0, req1, req2, req3, req4;
    logic gnt0, gnt1, gnt2, gnt3, gnt4;
    modport master (output req0, req1, req2, req3, req4, input gnt0, gnt1, gnt2, gnt3, gnt4);
    modport slave (input req0, req1, req2, req3, req4, output gnt0, gnt1, gnt2, gnt3, gnt4);
endinterface

// File: rtl/rr_arbiter5.sv
// rr_arbiter5: five-requester round-robin arbiter with registered one-hot grant
module rr_arbiter5 (
    input logic clk,
    input logic rst,
    rr_arbiter5_if.slave bus
);
    localparam int NUM_REQ = 5;
    logic [4:0] req, gnt_q, gnt_d;
    logic [2:0] last_q, last_d;
    logic found;
    int idx;
    assign req = {bus.req4, bus.req3, bus.req2, bus.req1, bus.req0};
    // Search starts just after the last winner and ends on it, wrapping 4 -> 0.
    always_comb begin
        gnt_d = '0;
        last_d = last_q;
        found = 1'b0;
        idx = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt_d[idx] = 1'b1;
                last_d = 3'(idx);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
            last_q <= 3'd4;
        end else begin
            gnt_q <= gnt_d;
            last_q <= last_d;
        end
    end
    assign {bus.gnt4, bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0} = gnt_q;
endmodule

// File: tb/tb_rr_arbiter5.sv
// tb_rr_arbiter5: directed-vector check of round-robin order, wrap, idle and reset
module tb_rr_arbiter5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [4:0] req_cur;
    logic [4:0] gnt;
    rr_arbiter5_if bus ();
    rr_arbiter5 dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    assign {bus.req4, bus.req3, bus.req2, bus.req1, bus.req0} = req_cur;
    assign gnt = {bus.gnt4, bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply a request vector, clock once, then check grant and invariants.
    task automatic step(input string tag, input logic [4:0] r, input logic [4:0] exp);
        req_cur = r;
        @(posedge clk);
        #1;
        check(tag, gnt, exp);
        check({tag, "_onehot"}, {4'b0, $onehot0(gnt)}, 5'b00001);
        check({tag, "_subset"}, gnt & ~r, 5'b00000);
    endtask

    initial begin
        rst = 1'b1;
        step("rst0", 5'b11111, 5'b00000);
        step("rst1", 5'b11111, 5'b00000);
        rst = 1'b0;
        step("all0", 5'b11111, 5'b00001);
        step("all1", 5'b11111, 5'b00010);
        step("all2", 5'b11111, 5'b00100);
        step("all3", 5'b11111, 5'b01000);
        step("all4", 5'b11111, 5'b10000);
        step("no0_0", 5'b11110, 5'b00010);
        step("no0_1", 5'b11110, 5'b00100);
        step("no0_2", 5'b11110, 5'b01000);
        step("no0_3", 5'b11110, 5'b10000);
        step("no0_4", 5'b11110, 5'b00010);
        step("no1_0", 5'b11101, 5'b00100);
        step("no1_1", 5'b11101, 5'b01000);
        step("no1_2", 5'b11101, 5'b10000);
        step("no1_3", 5'b11101, 5'b00001);
        step("no1_4", 5'b11101, 5'b00100);
        step("lone0", 5'b01000, 5'b01000);
        step("lone1", 5'b01000, 5'b01000);
        step("lone2", 5'b01000, 5'b01000);
        step("idle", 5'b00000, 5'b00000);
        step("after_idle", 5'b11111, 5'b10000);
        step("pre_rst0", 5'b11111, 5'b00001);
        step("pre_rst1", 5'b11111, 5'b00010);
        rst = 1'b1;
        step("mid_rst", 5'b11111, 5'b00000);
        rst = 1'b0;
        step("post_rst", 5'b11111, 5'b00001);
        step("pair_a", 5'b00101, 5'b00100);
        step("pair_b", 5'b00101, 5'b00001);
        step("wrap_4", 5'b10001, 5'b10000);
        step("wrap_0", 5'b10001, 5'b00001);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
